m68k_bram_responder: RTL and testbench
======================================

// Module: m68k_bram_responder
// PURPOSE
//  Bus responder (slave) for the WF68K 68020/030-style asynchronous memory bus in the simulation top.
//  Decodes the low address window, serves reads and writes from a 32-bit internal block RAM, and
//  terminates each cycle with DSACKn (32-bit port) and DBENn. It is the far end of the CPU's
//  ADR_OUT/DATA_OUT/RWn/SIZE initiator and replaces ad-hoc DSACK generation in the top level.
// PARAMETERS
//  ADDR_BITS    11    long-word address bits of the RAM (2**11 x 32 = 8 KB)
//  DECODE_HI    19    ADR_OUT[31:DECODE_HI] must be all zero for the cycle to be claimed
//  WAIT_STATES  1     extra CLK_114 cycles inserted before DSACKn assertion (0..15)
//  INIT_FILE    ""    $readmemh image loaded at elaboration when non-empty
// PORTS
//  CLK_114   in   1   system clock
//  RESET_N   in   1   synchronous, active-low reset
//  ASn       in   1   address strobe from CPU (asynchronous, active low)
//  DSn       in   1   data strobe from CPU (asynchronous, active low)
//  RWn       in   1   1 = read, 0 = write
//  SIZE      in   2   transfer size: 01 byte, 10 word, 11 three-byte, 00 long
//  ADR_OUT   in   32  byte address from CPU
//  DATA_OUT  in   32  write data from CPU, lane 0 = [31:24]
//  DATA_IN   out  32  read data to CPU, registered
//  DSACKn    out  2   data transfer acknowledge; 2'b00 = 32-bit port ack, 2'b11 = idle
//  DBENn     out  1   data buffer enable, low while this responder drives/accepts data
// BEHAVIOUR
//  - Reset (RESET_N=0 at CLK_114 edge): DSACKn=2'b11, DBENn=1, DATA_IN=0, FSM=IDLE, sync flops=1.
//    Reset mid-cycle aborts it; a write not yet committed is never performed. RAM contents kept.
//  - ASn, DSn pass a 2-flop synchronizer; FSM uses as_s/ds_s only.
//  - FSM: IDLE -> DECODE -> WAIT -> ACK -> IDLE; SKIP for unclaimed cycles.
//    IDLE:   as_s=0 -> latch ADR_OUT, RWn, SIZE, DATA_OUT; go DECODE.
//    DECODE: addr[31:DECODE_HI]!=0 -> SKIP. Else issue RAM read of addr[ADDR_BITS+1:2];
//            WAIT_STATES=0 -> ACK, else WAIT with counter=WAIT_STATES-1.
//    WAIT:   count down; at 0 -> ACK. as_s=1 at any point -> IDLE (abort, no write).
//    ACK entry (single edge): write = commit byte-lane write if ds_s=0, else hold in ACK
//            until ds_s=0 then commit once; read = DATA_IN <= RAM word. Then DSACKn=00, DBENn=0.
//    ACK:    hold outputs until as_s=1 -> DSACKn=11, DBENn=1 on that edge, go IDLE.
//    SKIP:   DSACKn/DBENn stay inactive; as_s=1 -> IDLE.
//  - Timing: ASn first sampled low at edge k -> DSACKn low after edge k+4+WAIT_STATES (read,
//    or write with DSn already low); ASn first sampled high at edge m -> DSACKn high after m+2.
//  - Byte lanes: first lane L=ADR_OUT[1:0], n = SIZE (00 -> 4); lanes L..min(3,L+n-1) enabled.
//    Lane i = bits [31-8i:24-8i]. Writes update only enabled lanes; DATA_OUT taken lane-for-lane
//    (CPU aligns operand). Reads return full long word; CPU selects lanes.
//  - Back-to-back cycles: a new ASn assertion is not accepted until FSM has returned to IDLE.
//  - RAM index wraps within 2**ADDR_BITS; no BERRn generated (unclaimed cycles time out upstream).
// TESTING
//  1 RAM[0x40]=0x11223344, read SIZE=00 ADR=0x100, W=1 -> DATA_IN=0x11223344, DSACKn=00 at k+5.
//  2 Byte write SIZE=01 ADR=0x103 DATA_OUT=0x000000AB over 0x11223344 -> RAM[0x40]=0x112233AB.
//  3 Word write SIZE=10 ADR=0x101 DATA_OUT=0x00BEEF00 over 0x11223344 -> RAM[0x40]=0x11BEEF44.
//  4 Read ADR=0x00080000 -> DSACKn stays 11, DBENn stays 1, FSM SKIP->IDLE after ASn negates.
//  5 Write, ASn negated during WAIT (WAIT_STATES=4) -> no RAM change, DSACKn never asserted.
//  6 RESET_N=0 while in ACK -> DSACKn=11, DBENn=1, DATA_IN=0 on next edge; next read correct.

Source files
------------

// File: rtl/m68k_bram_responder.sv
// Bus responder for the WF68K asynchronous memory bus: decodes a low address window,
// serves 32-bit block-RAM reads/writes and terminates each cycle with DSACKn/DBENn.
module m68k_bram_responder #(
    parameter int unsigned ADDR_BITS   = 11,
    parameter int unsigned DECODE_HI   = 19,
    parameter int unsigned WAIT_STATES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        CLK_114,
    input  logic        RESET_N,
    input  logic        ASn,
    input  logic        DSn,
    input  logic        RWn,
    input  logic [1:0]  SIZE,
    input  logic [31:0] ADR_OUT,
    input  logic [31:0] DATA_OUT,
    output logic [31:0] DATA_IN,
    output logic [1:0]  DSACKn,
    output logic        DBENn
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_WAIT   = 3'd2,
        S_ACK    = 3'd3,
        S_SKIP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_as_s1, r_as_s2, r_ds_s1, r_ds_s2;
    logic                 w_as_s, w_ds_s;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic                 r_rwn;
    logic [1:0]           r_size;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 r_acked;
    logic [31:0]          r_ram_q;
    logic [31:0]          r_data_in;
    logic [1:0]           r_dsackn;
    logic                 r_dbenn;
    logic [31:0]          r_mem [DEPTH];
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_hit;
    logic [2:0]           w_len;
    logic [3:0]           w_be;
    logic                 w_latch, w_rd_issue, w_commit, w_wr_en, w_rd_ld, w_release;
    logic                 w_unused_addr;

    assign w_as_s        = r_as_s2;
    assign w_ds_s        = r_ds_s2;
    assign w_idx         = r_addr[ADDR_BITS+1:2];
    assign w_hit         = ~|r_addr[31:DECODE_HI];
    assign w_unused_addr = ^r_addr[DECODE_HI-1:ADDR_BITS+2];

    // Two-flop synchronizers for the asynchronous strobes
    always_ff @(posedge CLK_114) begin
        if (!RESET_N) begin
            r_as_s1 <= 1'b1;
            r_as_s2 <= 1'b1;
            r_ds_s1 <= 1'b1;
            r_ds_s2 <= 1'b1;
        end else begin
            r_as_s1 <= ASn;
            r_as_s2 <= r_as_s1;
            r_ds_s1 <= DSn;
            r_ds_s2 <= r_ds_s1;
        end
    end

    always_ff @(posedge CLK_114) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // ACK is left on AS negation both after the acknowledge and as an abort before it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!w_as_s) w_state_nxt = S_DECODE;
            S_DECODE: begin
                if (!w_hit)                w_state_nxt = S_SKIP;
                else if (WAIT_STATES == 0) w_state_nxt = S_ACK;
                else                       w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_as_s)            w_state_nxt = S_IDLE;
                else if (r_cnt == '0)  w_state_nxt = S_ACK;
            end
            S_ACK:    if (w_as_s) w_state_nxt = S_IDLE;
            S_SKIP:   if (w_as_s) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath strobes; a write commits only once DS is seen and never while in reset
    always_comb begin
        w_latch    = (r_state == S_IDLE) && !w_as_s;
        w_rd_issue = (r_state == S_DECODE) && w_hit;
        w_commit   = RESET_N && (r_state == S_ACK) && !r_acked && !w_as_s && (r_rwn || !w_ds_s);
        w_wr_en    = w_commit && !r_rwn;
        w_rd_ld    = w_commit && r_rwn;
        w_release  = (r_state == S_ACK) && r_acked && w_as_s;
        w_cnt_nxt  = r_cnt;
        if (r_state == S_DECODE)
            w_cnt_nxt = CNT_W'(WAIT_STATES - 1);
        else if ((r_state == S_WAIT) && (r_cnt != '0))
            w_cnt_nxt = r_cnt - CNT_W'(1);
    end

    // Enabled lanes L..min(3, L+n-1); SIZE 00 means four bytes
    always_comb begin
        w_len = (r_size == 2'b00) ? 3'd4 : {1'b0, r_size};
        w_be  = '0;
        for (int i = 0; i < 4; i++) begin
            w_be[i] = (3'(i) >= {1'b0, r_addr[1:0]}) && (3'(i) < ({1'b0, r_addr[1:0]} + w_len));
        end
    end

    always_ff @(posedge CLK_114) begin
        if (!RESET_N) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rwn     <= 1'b1;
            r_size    <= '0;
            r_cnt     <= '0;
            r_acked   <= 1'b0;
            r_data_in <= '0;
            r_dsackn  <= 2'b11;
            r_dbenn   <= 1'b1;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_latch) begin
                r_addr  <= ADR_OUT;
                r_wdata <= DATA_OUT;
                r_rwn   <= RWn;
                r_size  <= SIZE;
            end
            if (r_state != S_ACK) r_acked <= 1'b0;
            else if (w_commit)    r_acked <= 1'b1;
            if (w_rd_ld) r_data_in <= r_ram_q;
            if (w_commit) begin
                r_dsackn <= 2'b00;
                r_dbenn  <= 1'b0;
            end else if (w_release) begin
                r_dsackn <= 2'b11;
                r_dbenn  <= 1'b1;
            end
        end
    end

    // Block RAM: synchronous read issued in DECODE, byte-lane write on commit
    always_ff @(posedge CLK_114) begin
        if (w_rd_issue) r_ram_q <= r_mem[w_idx];
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][31-8*i -: 8] <= r_wdata[31-8*i -: 8];
            end
        end
    end

    assign DATA_IN = r_data_in;
    assign DSACKn  = r_dsackn;
    assign DBENn   = r_dbenn;

endmodule

// File: tb/tb_m68k_bram_responder.sv
// Directed bench for m68k_bram_responder: instance A (1 wait state) runs the vector table,
// instance B (4 wait states) covers the abort-during-WAIT case.
module tb_m68k_bram_responder;

    logic        clk;
    logic        rst_n;
    logic        as_n_a, as_n_b, ds_n, rwn;
    logic [1:0]  size;
    logic [31:0] adr, dout;
    logic [31:0] din_a, din_b;
    logic [1:0]  dsack_a, dsack_b;
    logic        dben_a, dben_b;

    int checks = 0;
    int errors = 0;

    m68k_bram_responder #(.WAIT_STATES(1)) dut_a (
        .CLK_114(clk), .RESET_N(rst_n), .ASn(as_n_a), .DSn(ds_n), .RWn(rwn), .SIZE(size),
        .ADR_OUT(adr), .DATA_OUT(dout), .DATA_IN(din_a), .DSACKn(dsack_a), .DBENn(dben_a)
    );

    m68k_bram_responder #(.WAIT_STATES(4)) dut_b (
        .CLK_114(clk), .RESET_N(rst_n), .ASn(as_n_b), .DSn(ds_n), .RWn(rwn), .SIZE(size),
        .ADR_OUT(adr), .DATA_OUT(dout), .DATA_IN(din_b), .DSACKn(dsack_b), .DBENn(dben_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rwn;
        logic [1:0]  size;
        logic [31:0] adr;
        logic [31:0] dout;
        bit          claimed;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ack_of(input bit sel_b);
        return sel_b ? dsack_b : dsack_a;
    endfunction

    function automatic logic dben_of(input bit sel_b);
        return sel_b ? dben_b : dben_a;
    endfunction

    // Full bus cycle with DS asserted together with AS; checks latency, data and release
    task automatic bus_cycle(input bit sel_b, input logic r, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] d, input bit claimed,
                             input logic [31:0] exp, input string name);
        int lat;
        bit dben_seen;
        lat = 0;
        dben_seen = 0;
        rwn = r; size = sz; adr = a; dout = d; ds_n = 1'b0;
        if (sel_b) as_n_b = 1'b0; else as_n_a = 1'b0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick();
            if (ack_of(sel_b) == 2'b00) lat = c;
            if (dben_of(sel_b) == 1'b0) dben_seen = 1;
        end
        if (claimed) begin
            check({name, " ack latency"}, 32'(lat), sel_b ? 32'd9 : 32'd6);
            check({name, " dben at ack"}, 32'(dben_of(sel_b)), 32'd0);
            if (r) check({name, " read data"}, sel_b ? din_b : din_a, exp);
        end else begin
            check({name, " no ack"}, 32'(lat), 32'd0);
            check({name, " no dben"}, 32'(dben_seen), 32'd0);
        end
        as_n_a = 1'b1; as_n_b = 1'b1; ds_n = 1'b1;
        tick();
        tick();
        if (claimed) check({name, " ack held"}, 32'(ack_of(sel_b)), 32'd0);
        tick();
        check({name, " ack released"}, 32'(ack_of(sel_b)), 32'd3);
        check({name, " dben released"}, 32'(dben_of(sel_b)), 32'd1);
        tick();
    endtask

    initial begin
        bit seen;
        int lat;

        vecs[0]  = '{1'b0, 2'b00, 32'h0000_0100, 32'h1122_3344, 1'b1, 32'h0};
        vecs[1]  = '{1'b1, 2'b00, 32'h0000_0100, 32'h0,         1'b1, 32'h1122_3344};
        vecs[2]  = '{1'b0, 2'b01, 32'h0000_0103, 32'h0000_00AB, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 2'b00, 32'h0000_0100, 32'h0,         1'b1, 32'h1122_33AB};
        vecs[4]  = '{1'b0, 2'b00, 32'h0000_0100, 32'h1122_3344, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 2'b10, 32'h0000_0101, 32'h00BE_EF00, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 2'b00, 32'h0000_0100, 32'h0,         1'b1, 32'h11BE_EF44};
        vecs[7]  = '{1'b0, 2'b00, 32'h0000_0200, 32'h5566_7788, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 2'b11, 32'h0000_0201, 32'hFFA1_B2C3, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 2'b00, 32'h0000_0200, 32'h0,         1'b1, 32'h55A1_B2C3};
        vecs[10] = '{1'b0, 2'b10, 32'h0000_0203, 32'h0000_00EE, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 2'b00, 32'h0000_0200, 32'h0,         1'b1, 32'h55A1_B2EE};
        vecs[12] = '{1'b0, 2'b00, 32'h0000_2100, 32'hCAFE_F00D, 1'b1, 32'h0};
        vecs[13] = '{1'b1, 2'b00, 32'h0000_0100, 32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[14] = '{1'b1, 2'b00, 32'h0008_0000, 32'h0,         1'b0, 32'h0};
        vecs[15] = '{1'b0, 2'b00, 32'h0007_FFFC, 32'h0BAD_BEEF, 1'b1, 32'h0};
        vecs[16] = '{1'b1, 2'b00, 32'h0007_FFFC, 32'h0,         1'b1, 32'h0BAD_BEEF};
        vecs[17] = '{1'b0, 2'b01, 32'h0000_0200, 32'h9900_0000, 1'b1, 32'h0};
        vecs[18] = '{1'b1, 2'b00, 32'h0000_0200, 32'h0,         1'b1, 32'h99A1_B2EE};

        rst_n = 1'b0; as_n_a = 1'b1; as_n_b = 1'b1; ds_n = 1'b1; rwn = 1'b1;
        size = 2'b00; adr = '0; dout = '0;
        tick(); tick(); tick();
        check("reset dsack_a", 32'(dsack_a), 32'd3);
        check("reset dben_a", 32'(dben_a), 32'd1);
        check("reset data_a", din_a, 32'h0);
        check("reset dsack_b", 32'(dsack_b), 32'd3);
        rst_n = 1'b1;
        tick(); tick();

        for (int i = 0; i < 19; i++) begin
            bus_cycle(1'b0, vecs[i].rwn, vecs[i].size, vecs[i].adr, vecs[i].dout,
                      vecs[i].claimed, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Write held in ACK until DS arrives late
        rwn = 1'b0; size = 2'b00; adr = 32'h0000_0300; dout = 32'h1357_9BDF;
        ds_n = 1'b1; as_n_a = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (dsack_a == 2'b00) seen = 1;
        end
        check("late ds no early ack", 32'(seen), 32'd0);
        ds_n = 1'b0;
        tick(); tick();
        check("late ds ack not yet", 32'(dsack_a), 32'd3);
        tick();
        check("late ds ack", 32'(dsack_a), 32'd0);
        as_n_a = 1'b1; ds_n = 1'b1;
        tick(); tick(); tick(); tick();
        bus_cycle(1'b0, 1'b1, 2'b00, 32'h0000_0300, 32'h0, 1'b1, 32'h1357_9BDF, "late ds readback");

        // Reset while acknowledging a read
        rwn = 1'b1; size = 2'b00; adr = 32'h0000_0100; ds_n = 1'b0; as_n_a = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick();
            if (dsack_a == 2'b00) lat = c;
        end
        check("pre-reset ack latency", 32'(lat), 32'd6);
        check("pre-reset data", din_a, 32'hCAFE_F00D);
        rst_n = 1'b0; as_n_a = 1'b1; ds_n = 1'b1;
        tick();
        check("mid reset dsack", 32'(dsack_a), 32'd3);
        check("mid reset dben", 32'(dben_a), 32'd1);
        check("mid reset data", din_a, 32'h0);
        rst_n = 1'b1;
        tick(); tick();
        bus_cycle(1'b0, 1'b1, 2'b00, 32'h0000_0100, 32'h0, 1'b1, 32'hCAFE_F00D, "post reset read");

        // Instance B: abort a write by negating AS during WAIT
        bus_cycle(1'b1, 1'b0, 2'b00, 32'h0000_0100, 32'h1111_1111, 1'b1, 32'h0, "b write");
        rwn = 1'b0; size = 2'b00; adr = 32'h0000_0100; dout = 32'h9999_9999;
        ds_n = 1'b0; as_n_b = 1'b0;
        tick(); tick(); tick(); tick();
        as_n_b = 1'b1; ds_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (dsack_b == 2'b00 || dben_b == 1'b0) seen = 1;
        end
        check("abort no ack", 32'(seen), 32'd0);
        bus_cycle(1'b1, 1'b1, 2'b00, 32'h0000_0100, 32'h0, 1'b1, 32'h1111_1111, "abort readback");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
